// File: rtl/pipelined_shift_unit_pkg.sv
// Shared shift-mode encodings and sizing helpers for pipelined_shift_unit.
package pipelined_shift_unit_pkg;

  typedef enum logic [1:0] {
    MODE_LSL = 2'd0,
    MODE_LSR = 2'd1,
    MODE_ASR = 2'd2,
    MODE_ROR = 2'd3
  } shift_mode_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  // Pipeline depth in cycles: one register per reg_every stages, one after the last.
  function automatic int unsigned latency(input int unsigned width, input int unsigned reg_every);
    int unsigned l;
    l = (clog2(width) + reg_every - 1) / reg_every;
    return (l == 0) ? 1 : l;
  endfunction

endpackage

// File: rtl/pipelined_shift_unit_shift_stage.sv
// One log-shifter stage: conditionally shifts by 2^k in the selected mode.
// Sticky tracking is built only when PIPELINED_SHIFT_UNIT_STICKY_EN is defined.
module pipelined_shift_unit_shift_stage
  import pipelined_shift_unit_pkg::*;
#(
  parameter int unsigned width = 8,
  parameter int unsigned k     = 0
) (
  input  logic [width-1:0] data_i,
  input  shift_mode_e      mode_i,
  input  logic             en_i,
`ifdef PIPELINED_SHIFT_UNIT_STICKY_EN
  input  logic             sticky_i,
  output logic             sticky_o,
`endif
  output logic [width-1:0] data_o
);

  localparam int unsigned Dist = 1 << k;

  logic [width-1:0] shifted;

  always_comb begin
    shifted = data_i;
    unique case (mode_i)
      MODE_LSL: shifted = data_i << Dist;
      MODE_LSR: shifted = data_i >> Dist;
      MODE_ASR: shifted = $signed(data_i) >>> Dist;
      MODE_ROR: shifted = (data_i >> Dist) | (data_i << (width - Dist));
    endcase
  end

  assign data_o = en_i ? shifted : data_i;

`ifdef PIPELINED_SHIFT_UNIT_STICKY_EN
  // Bits falling off the right end of this stage.
  localparam logic [width-1:0] LowMask = {{(width - Dist){1'b0}}, {Dist{1'b1}}};

  assign sticky_o = sticky_i | (en_i && (mode_i == MODE_LSR || mode_i == MODE_ASR) &&
                                (|(data_i & LowMask)));
`endif

endmodule

// File: rtl/pipelined_shift_unit.sv
// Pipelined barrel shifter (LSL/LSR/ASR/ROR) with a valid/ready stream interface.
// Defining PIPELINED_SHIFT_UNIT_STICKY_EN adds the o_sticky output and its logic.
module pipelined_shift_unit
  import pipelined_shift_unit_pkg::*;
#(
  parameter int unsigned  width     = 8,
  parameter int unsigned  reg_every = 1,
  localparam int unsigned NumStages = clog2(width)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [width-1:0]     i_bits,
  input  logic [NumStages-1:0] i_shift,
  input  logic [1:0]           i_mode,
  output logic                 o_valid,
  input  logic                 o_ready,
`ifdef PIPELINED_SHIFT_UNIT_STICKY_EN
  output logic                 o_sticky,
`endif
  output logic [width-1:0]     o_bits
);

  localparam int unsigned Latency = latency(width, reg_every);

  if (width < 2 || reg_every < 1 || Latency < 1) begin : g_param_check
    $error("pipelined_shift_unit: width must be >= 2 and reg_every >= 1");
  end

  logic stall;
  assign stall   = o_valid & ~o_ready;
  assign i_ready = ~stall;

  // ROR by an amount >= width wraps once; i_shift < 2*width so one subtraction is enough.
  logic [NumStages-1:0] pre_shift;
  always_comb begin
    pre_shift = i_shift;
    if (shift_mode_e'(i_mode) == MODE_ROR && 32'(i_shift) >= width) begin
      pre_shift = i_shift - NumStages'(width);
    end
  end

  for (genvar k = 0; k < NumStages; k++) begin : g_stage
    localparam bit IsReg = ((k + 1) % reg_every == 0) || (k == NumStages - 1);

    logic [width-1:0]     in_data, data_d, p_data;
    shift_mode_e          in_mode, p_mode;
    logic [NumStages-1:0] in_shift, p_shift;
    logic                 in_valid, p_valid;
`ifdef PIPELINED_SHIFT_UNIT_STICKY_EN
    logic                 in_sticky, sticky_d, p_sticky;
`endif

    if (k == 0) begin : g_first
      assign in_data  = i_bits;
      assign in_mode  = shift_mode_e'(i_mode);
      assign in_shift = pre_shift;
      assign in_valid = i_valid;
`ifdef PIPELINED_SHIFT_UNIT_STICKY_EN
      assign in_sticky = 1'b0;
`endif
    end else begin : g_next
      assign in_data  = g_stage[k-1].p_data;
      assign in_mode  = g_stage[k-1].p_mode;
      assign in_shift = g_stage[k-1].p_shift;
      assign in_valid = g_stage[k-1].p_valid;
`ifdef PIPELINED_SHIFT_UNIT_STICKY_EN
      assign in_sticky = g_stage[k-1].p_sticky;
`endif
    end

    pipelined_shift_unit_shift_stage #(
      .width (width),
      .k     (k)
    ) u_stage (
      .data_i   (in_data),
      .mode_i   (in_mode),
      .en_i     (in_shift[k]),
`ifdef PIPELINED_SHIFT_UNIT_STICKY_EN
      .sticky_i (in_sticky),
      .sticky_o (sticky_d),
`endif
      .data_o   (data_d)
    );

    if (IsReg) begin : g_reg
      logic [width-1:0]     data_q;
      shift_mode_e          mode_q;
      logic [NumStages-1:0] shift_q;
      logic                 valid_q;
`ifdef PIPELINED_SHIFT_UNIT_STICKY_EN
      logic                 sticky_q;
`endif

      // Whole pipe holds while the output is stalled; bubbles advance otherwise.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q  <= 1'b0;
          data_q   <= '0;
          mode_q   <= MODE_LSL;
          shift_q  <= '0;
`ifdef PIPELINED_SHIFT_UNIT_STICKY_EN
          sticky_q <= 1'b0;
`endif
        end else if (!stall) begin
          valid_q  <= in_valid;
          data_q   <= data_d;
          mode_q   <= in_mode;
          shift_q  <= in_shift;
`ifdef PIPELINED_SHIFT_UNIT_STICKY_EN
          sticky_q <= sticky_d;
`endif
        end
      end

      assign p_data  = data_q;
      assign p_mode  = mode_q;
      assign p_shift = shift_q;
      assign p_valid = valid_q;
`ifdef PIPELINED_SHIFT_UNIT_STICKY_EN
      assign p_sticky = sticky_q;
`endif
    end else begin : g_comb
      assign p_data  = data_d;
      assign p_mode  = in_mode;
      assign p_shift = in_shift;
      assign p_valid = in_valid;
`ifdef PIPELINED_SHIFT_UNIT_STICKY_EN
      assign p_sticky = sticky_d;
`endif
    end
  end

  assign o_valid = g_stage[NumStages-1].p_valid;
  assign o_bits  = g_stage[NumStages-1].p_data;
`ifdef PIPELINED_SHIFT_UNIT_STICKY_EN
  assign o_sticky = g_stage[NumStages-1].p_sticky;
`endif

endmodule

// File: tb/tb_pipelined_shift_unit.sv
// Scoreboard bench for pipelined_shift_unit over several width/reg_every configurations.
module tb_pipelined_shift_unit;

  localparam int NumCfg = 3;
  localparam int CfgW  [NumCfg] = '{8, 6, 16};
  localparam int CfgRe [NumCfg] = '{1, 2, 1};

  typedef struct packed {
    logic [15:0] bits;
    logic        sticky;
    logic        lat_chk;
    int          cyc;
  } exp_t;

  bit clk = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit done [NumCfg];

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  for (genvar g = 0; g < NumCfg; g++) begin : g_cfg
    localparam int W  = CfgW[g];
    localparam int Re = CfgRe[g];
    localparam int S  = $clog2(W);
    localparam int L  = (S + Re - 1) / Re;

    logic         rst, i_valid, i_ready, o_valid, o_ready, lat_chk, rst_q, stall_prev, acc;
    logic [W-1:0] i_bits, o_bits, held;
    logic [S-1:0] i_shift;
    logic [1:0]   i_mode;
`ifdef PIPELINED_SHIFT_UNIT_STICKY_EN
    logic         o_sticky;
`endif
    exp_t         q [$];
    int           bp_cnt;

    pipelined_shift_unit #(
      .width     (W),
      .reg_every (Re)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .i_valid  (i_valid),
      .i_ready  (i_ready),
      .i_bits   (i_bits),
      .i_shift  (i_shift),
      .i_mode   (i_mode),
      .o_valid  (o_valid),
      .o_ready  (o_ready),
`ifdef PIPELINED_SHIFT_UNIT_STICKY_EN
      .o_sticky (o_sticky),
`endif
      .o_bits   (o_bits)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      check($sformatf("w%0d/re%0d %s", W, Re, nm), act, req);
    endtask

    // Bit-level reference: out[i] picks the source bit each mode's definition names.
    function automatic exp_t model(input logic [W-1:0] b, input int n, input int m);
      exp_t e;
      e = '0;
      for (int i = 0; i < W; i++) begin
        case (m)
          0: if (i >= n) e.bits[i] = b[i - n];
          1: if (i + n < W) e.bits[i] = b[i + n];
          2: begin
            if (i + n < W) e.bits[i] = b[i + n];
            else e.bits[i] = b[W - 1];
          end
          default: e.bits[i] = b[(i + n) % W];
        endcase
        if ((m == 1 || m == 2) && i < n) e.sticky = e.sticky | b[i];
      end
      return e;
    endfunction

    always @(posedge clk) rst_q <= rst;

    // Stimulus side: record every beat the next edge will accept.
    always @(negedge clk) begin
      if (rst) begin
        q.delete();
      end else if (i_valid && i_ready) begin
        exp_t e;
        e = model(i_bits, int'(i_shift), int'(i_mode));
        e.lat_chk = lat_chk;
        e.cyc     = cyc;
        q.push_back(e);
      end
    end

    // Monitor side: handshake rules, stall stability and in-order delivery.
    always @(negedge clk) begin
      if (cyc > 0) begin
        exp_t e;
        if (rst_q) begin
          chk("reset o_valid", o_valid, 0);
          chk("reset o_bits", o_bits, 0);
`ifdef PIPELINED_SHIFT_UNIT_STICKY_EN
          chk("reset o_sticky", o_sticky, 0);
`endif
        end
        chk("i_ready", i_ready, !(o_valid && !o_ready));
        if (stall_prev) begin
          chk("stall o_valid", o_valid, 1);
          chk("stall o_bits", o_bits, held);
        end
        if (!rst && o_valid && o_ready) begin
          if (q.size() == 0) begin
            chk("o_valid with no beat outstanding", o_valid, 0);
          end else begin
            e = q.pop_front();
            chk("o_bits", o_bits, e.bits[W-1:0]);
`ifdef PIPELINED_SHIFT_UNIT_STICKY_EN
            chk("o_sticky", o_sticky, e.sticky);
`endif
            if (e.lat_chk) chk("latency", cyc - e.cyc, L);
          end
        end
        stall_prev <= !rst && o_valid && !o_ready;
        held       <= o_bits;
      end
    end

    task automatic step(input bit bp);
      if (bp) begin
        o_ready = (bp_cnt % 3 == 0);
        bp_cnt++;
      end else begin
        o_ready = 1'b1;
      end
      @(negedge clk);
      acc = i_valid && i_ready;
      @(posedge clk);
      #1;
    endtask

    task automatic send(input logic [W-1:0] b, input int sh, input int m, input bit bp);
      bit ok;
      ok = 0;
      i_valid = 1'b1;
      i_bits  = b;
      i_shift = S'(sh);
      i_mode  = 2'(m);
      for (int t = 0; t < 50 && !ok; t++) begin
        step(bp);
        ok = acc;
      end
      if (!ok) chk("accept timeout i_ready", i_ready, 1);
    endtask

    task automatic send_rand(input bit bp);
      send(W'($urandom), int'($urandom_range(0, (1 << S) - 1)), int'($urandom_range(0, 3)), bp);
    endtask

    task automatic drain();
      i_valid = 1'b0;
      for (int t = 0; t < 60 && (q.size() != 0 || o_valid); t++) step(0);
      chk("scoreboard empty", q.size(), 0);
    endtask

    initial begin
      rst        = 1'b1;
      i_valid    = 1'b1;
      i_bits     = W'($urandom);
      i_shift    = '0;
      i_mode     = '0;
      o_ready    = 1'b1;
      lat_chk    = 1'b1;
      bp_cnt     = 0;
      stall_prev = 1'b0;
      held       = '0;
      acc        = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      // The beat left on the bus through reset is the first one accepted.
      step(0);
      i_valid = 1'b0;

      if (W == 8) begin
        for (int m = 0; m < 4; m++) send(W'(8'hB4), 3, m, 0);
        send(W'(8'hB0), 3, 1, 0);
        send(W'(8'hB0), 3, 2, 0);
      end else if (W == 6) begin
        for (int m = 0; m < 4; m++) send(W'(6'h25), 7, m, 0);
      end
      for (int m = 0; m < 4; m++) send(W'($urandom), 0, m, 0);
      for (int t = 0; t < 20; t++) send_rand(0);
      drain();

      lat_chk = 1'b0;
      for (int t = 0; t < 10; t++) send_rand(1);
      drain();
      lat_chk = 1'b1;

      // Fill the pipe without letting any beat reach the consumer, then reset.
      for (int t = 0; t < ((L < 3) ? L : 3); t++) send_rand(0);
      rst     = 1'b1;
      i_valid = 1'b0;
      step(0);
      rst = 1'b0;
      repeat (L + 2) step(0);
      send_rand(0);
      drain();
      done[g] = 1'b1;
    end
  end

  initial begin
    wait (done[0] && done[1] && done[2]);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected all configurations done");
    $fatal(1, "watchdog expired");
  end

endmodule
